// File: rtl/pipe_ctrl_unit.sv
// Pipeline stall/flush master: exception/EXRT commit, control registers and IRQ detection.
// Defining PIPE_CTRL_EXP_CNT_EN adds the exception counter at CR 5.
module pipe_ctrl_unit #(
  parameter int                ADDR_W     = 30,
  parameter int                DATA_W     = 32,
  parameter int                N_IRQ      = 8,
  parameter logic [ADDR_W-1:0] EXP_VECTOR = 30'h0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_busy,
  input  logic              mem_busy,
  input  logic              ld_hazard,
  input  logic [ADDR_W-1:0] mem_pc,
  input  logic              mem_en,
  input  logic              mem_br_flag,
  input  logic [2:0]        mem_exp_code,
  input  logic [1:0]        mem_ctrl_op,
  input  logic [2:0]        mem_cr_addr,
  input  logic [DATA_W-1:0] mem_wr_data,
  input  logic [2:0]        cr_rd_addr,
  output logic [DATA_W-1:0] cr_rd_data,
  input  logic [N_IRQ-1:0]  irq,
  output logic              int_detect,
  output logic              if_stall,
  output logic              id_stall,
  output logic              ex_stall,
  output logic              mem_stall,
  output logic              if_flush,
  output logic              id_flush,
  output logic              ex_flush,
  output logic              mem_flush,
  output logic [ADDR_W-1:0] new_pc
);

  localparam logic [2:0] EXP_NONE  = 3'd0;
  localparam logic [1:0] OP_WRCR   = 2'd1;
  localparam logic [1:0] OP_EXRT   = 2'd2;
  localparam logic [2:0] CR_STATUS = 3'd0;
  localparam logic [2:0] CR_MASK   = 3'd1;
  localparam logic [2:0] CR_EPC    = 3'd2;
  localparam logic [2:0] CR_CAUSE  = 3'd3;
  localparam logic [2:0] CR_PEND   = 3'd4;

  logic              raw_busy_s, busy_s, commit_s;
  logic              exp_commit_s, exrt_commit_s, wrcr_commit_s, hazard_s, flush_all_s;
  logic              ie_r, pie_r, ie_nxt_s, pie_nxt_s, inflight_r;
  logic [N_IRQ-1:0]  mask_r, mask_nxt_s, pend_r, pend_nxt_s, sync1_r, sync2_r;
  logic [ADDR_W-1:0] epc_r, epc_nxt_s, epc_adj_s;
  logic [3:0]        cause_r, cause_nxt_s;

  // Every decoded action is qualified by rst so the outputs stay quiet during reset.
  assign raw_busy_s    = if_busy | mem_busy;
  assign busy_s        = rst & raw_busy_s;
  assign commit_s      = rst & ~raw_busy_s & mem_en;
  assign exp_commit_s  = commit_s & (mem_exp_code != EXP_NONE);
  assign exrt_commit_s = commit_s & (mem_exp_code == EXP_NONE) & (mem_ctrl_op == OP_EXRT);
  assign wrcr_commit_s = commit_s & (mem_exp_code == EXP_NONE) & (mem_ctrl_op == OP_WRCR);
  assign hazard_s      = rst & ~raw_busy_s & ld_hazard & ~exp_commit_s & ~exrt_commit_s & ~wrcr_commit_s;
  assign flush_all_s   = exp_commit_s | exrt_commit_s;
  assign epc_adj_s     = mem_br_flag ? (mem_pc - ADDR_W'(1'b1)) : mem_pc;

  assign int_detect = rst & ie_r & (|(pend_r & mask_r)) & ~inflight_r
                      & ~busy_s & ~flush_all_s & ~hazard_s;

  // Stall/flush generation and redirect target.
  always_comb begin
    if_stall  = 1'b0;
    id_stall  = 1'b0;
    ex_stall  = 1'b0;
    mem_stall = 1'b0;
    if_flush  = 1'b0;
    id_flush  = 1'b0;
    ex_flush  = 1'b0;
    mem_flush = 1'b0;
    new_pc    = {ADDR_W{1'b0}};
    if (busy_s) begin
      if_stall  = 1'b1;
      id_stall  = 1'b1;
      ex_stall  = 1'b1;
      mem_stall = 1'b1;
    end else if (flush_all_s) begin
      if_flush  = 1'b1;
      id_flush  = 1'b1;
      ex_flush  = 1'b1;
      mem_flush = 1'b1;
      new_pc    = exp_commit_s ? EXP_VECTOR : epc_r;
    end else if (hazard_s) begin
      if_stall = 1'b1;
      id_stall = 1'b1;
      ex_flush = 1'b1;
    end else begin
      new_pc = {ADDR_W{1'b0}};
    end
  end

  // Next-state of the control registers; INT_PEND set beats a simultaneous W1C.
  always_comb begin
    ie_nxt_s    = ie_r;
    pie_nxt_s   = pie_r;
    mask_nxt_s  = mask_r;
    epc_nxt_s   = epc_r;
    cause_nxt_s = cause_r;
    pend_nxt_s  = pend_r | sync2_r;
    if (exp_commit_s) begin
      epc_nxt_s   = epc_adj_s;
      cause_nxt_s = {mem_br_flag, mem_exp_code};
      pie_nxt_s   = ie_r;
      ie_nxt_s    = 1'b0;
    end else if (exrt_commit_s) begin
      ie_nxt_s = pie_r;
    end else if (wrcr_commit_s) begin
      case (mem_cr_addr)
        CR_STATUS: begin
          pie_nxt_s = mem_wr_data[1];
          ie_nxt_s  = mem_wr_data[0];
        end
        CR_MASK:  mask_nxt_s  = mem_wr_data[N_IRQ-1:0];
        CR_EPC:   epc_nxt_s   = mem_wr_data[ADDR_W-1:0];
        CR_CAUSE: cause_nxt_s = mem_wr_data[3:0];
        CR_PEND:  pend_nxt_s  = (pend_r & ~mem_wr_data[N_IRQ-1:0]) | sync2_r;
        default:  pend_nxt_s  = pend_r | sync2_r;
      endcase
    end else begin
      ie_nxt_s = ie_r;
    end
  end

`ifdef PIPE_CTRL_EXP_CNT_EN
  localparam logic [2:0] CR_CNT = 3'd5;
  logic [31:0] cnt_r, cnt_nxt_s;

  // Exception counter next value; a WRCR write takes precedence over counting.
  always_comb begin
    cnt_nxt_s = cnt_r;
    if (wrcr_commit_s && (mem_cr_addr == CR_CNT)) begin
      cnt_nxt_s = mem_wr_data[31:0];
    end else if (exp_commit_s) begin
      cnt_nxt_s = cnt_r + 32'd1;
    end else begin
      cnt_nxt_s = cnt_r;
    end
  end

  // Exception counter register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_r <= 32'd0;
    end else begin
      cnt_r <= cnt_nxt_s;
    end
  end
`else
  logic unused_wr_data_s;
  assign unused_wr_data_s = ^mem_wr_data;
`endif

  // CR read port: returns the post-edge value so same-cycle writes are forwarded.
  always_comb begin
    cr_rd_data = {DATA_W{1'b0}};
    case (cr_rd_addr)
      CR_STATUS: cr_rd_data = DATA_W'({pie_nxt_s, ie_nxt_s});
      CR_MASK:   cr_rd_data = DATA_W'(mask_nxt_s);
      CR_EPC:    cr_rd_data = DATA_W'(epc_nxt_s);
      CR_CAUSE:  cr_rd_data = DATA_W'(cause_nxt_s);
      CR_PEND:   cr_rd_data = (wrcr_commit_s && (mem_cr_addr == CR_PEND)) ?
                              DATA_W'(pend_nxt_s) : DATA_W'(pend_r);
`ifdef PIPE_CTRL_EXP_CNT_EN
      CR_CNT:    cr_rd_data = DATA_W'(cnt_nxt_s);
`endif
      default:   cr_rd_data = {DATA_W{1'b0}};
    endcase
  end

  // Control register file.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ie_r    <= 1'b0;
      pie_r   <= 1'b0;
      mask_r  <= {N_IRQ{1'b0}};
      epc_r   <= {ADDR_W{1'b0}};
      cause_r <= 4'd0;
      pend_r  <= {N_IRQ{1'b0}};
    end else begin
      ie_r    <= ie_nxt_s;
      pie_r   <= pie_nxt_s;
      mask_r  <= mask_nxt_s;
      epc_r   <= epc_nxt_s;
      cause_r <= cause_nxt_s;
      pend_r  <= pend_nxt_s;
    end
  end

  // Two-flop IRQ synchronizer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_r <= {N_IRQ{1'b0}};
      sync2_r <= {N_IRQ{1'b0}};
    end else begin
      sync1_r <= irq;
      sync2_r <= sync1_r;
    end
  end

  // One tagged instruction per interrupt entry; cleared when an exception commits.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      inflight_r <= 1'b0;
    end else if (exp_commit_s) begin
      inflight_r <= 1'b0;
    end else if (int_detect) begin
      inflight_r <= 1'b1;
    end else begin
      inflight_r <= inflight_r;
    end
  end

endmodule
